// File: rtl/comparator_pkg.sv
// Shared definitions for the branch-condition comparator: operand width,
// CTRL branch codes and the branch-decision decode.
package comparator_pkg;

  localparam int unsigned CMP_WIDTH = 16;
  localparam int unsigned CTRL_W    = 3;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t CMP_NONE = 3'b000;
  localparam ctrl_t CMP_BEQ  = 3'b001;
  localparam ctrl_t CMP_BLT  = 3'b010;
  localparam ctrl_t CMP_BGT  = 3'b011;
  localparam ctrl_t CMP_JMP  = 3'b100;

  // Branch-taken decision. Reserved codes (101-111) never branch.
  function automatic logic branch_taken(input ctrl_t ctrl, input logic eq,
                                        input logic lt, input logic gt);
    logic taken;
    taken = 1'b0;
    case (ctrl)
      CMP_NONE: taken = 1'b0;
      CMP_BEQ:  taken = eq;
      CMP_BLT:  taken = lt;
      CMP_BGT:  taken = gt;
      CMP_JMP:  taken = 1'b1;
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/comparator_core.sv
// Combinational relation flags between r0 and op1.
// Define COMPARATOR_SIGNED_EN for two's-complement lt/gt; otherwise unsigned.
module comparator_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] op1,
  output logic             eq_c,
  output logic             lt_c,
  output logic             gt_c
);

  always_comb begin
    eq_c = (r0 == op1);
`ifdef COMPARATOR_SIGNED_EN
    lt_c = ($signed(r0) < $signed(op1));
    gt_c = ($signed(r0) > $signed(op1));
`else
    lt_c = (r0 < op1);
    gt_c = (r0 > op1);
`endif
  end

endmodule

// File: rtl/comparator.sv
// Branch-condition unit: registers eq/lt/gt and the PCSrc branch decision.
// Signedness of lt/gt follows COMPARATOR_SIGNED_EN (see comparator_core).
module comparator
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = CMP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] op1,
  input  logic [2:0]       CTRL,
  output logic             PCSrc,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  logic eq_c;
  logic lt_c;
  logic gt_c;
  logic pcsrc_c;

  comparator_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .r0   (r0),
    .op1  (op1),
    .eq_c (eq_c),
    .lt_c (lt_c),
    .gt_c (gt_c)
  );

  always_comb begin
    pcsrc_c = 1'b0;
    pcsrc_c = branch_taken(ctrl_t'(CTRL), eq_c, lt_c, gt_c);
  end

  // Reset wins over the inputs and drops any decision in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      PCSrc <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
      gt    <= 1'b0;
    end else begin
      PCSrc <= pcsrc_c;
      eq    <= eq_c;
      lt    <= lt_c;
      gt    <= gt_c;
    end
  end

endmodule

// File: tb/tb_comparator.sv
// Directed self-checking bench for comparator; outputs checked as {PCSrc,eq,lt,gt}.
module tb_comparator;

  logic        clk;
  logic        rst;
  logic [15:0] r0;
  logic [15:0] op1;
  logic [2:0]  CTRL;
  logic        PCSrc;
  logic        eq;
  logic        lt;
  logic        gt;

  int n_checks;
  int n_fail;

  comparator #(
    .WIDTH (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .r0    (r0),
    .op1   (op1),
    .CTRL  (CTRL),
    .PCSrc (PCSrc),
    .eq    (eq),
    .lt    (lt),
    .gt    (gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c);
    @(negedge clk);
    r0   = a;
    op1  = b;
    CTRL = c;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] got;
    rst = 1'b1;
    drive(16'h0000, 16'h0000, 3'b100);
    for (int i = 0; i < 2; i++) begin
      step();
      got = {PCSrc, eq, lt, gt};
      n_checks++;
      if (got !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold_%0d got=%b want=0000", i, got);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    got = {PCSrc, eq, lt, gt};
    n_checks++;
    if (got !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_release got=%b want=1100", got);
    end
  endtask

  task automatic test_beq;
    logic [3:0] got;
    drive(16'hFF0F, 16'hFF0F, 3'b001);
    step();
    got = {PCSrc, eq, lt, gt};
    n_checks++;
    if (got !== 4'b1100) begin
      n_fail++;
      $display("FAIL beq_equal got=%b want=1100", got);
    end
    drive(16'hFFF0, 16'hFF00, 3'b001);
    step();
    got = {PCSrc, eq, lt, gt};
    n_checks++;
    if (got !== 4'b0001) begin
      n_fail++;
      $display("FAIL beq_greater got=%b want=0001", got);
    end
  endtask

  task automatic test_blt;
    logic [3:0] got;
    drive(16'h4545, 16'h4546, 3'b010);
    step();
    got = {PCSrc, eq, lt, gt};
    n_checks++;
    if (got !== 4'b1010) begin
      n_fail++;
      $display("FAIL blt_less got=%b want=1010", got);
    end
    drive(16'hFF0F, 16'hCFCF, 3'b010);
    step();
    got = {PCSrc, eq, lt, gt};
    n_checks++;
    if (got !== 4'b0001) begin
      n_fail++;
      $display("FAIL blt_greater got=%b want=0001", got);
    end
  endtask

  task automatic test_bgt;
    logic [3:0] got;
    drive(16'hFFF0, 16'hFF00, 3'b011);
    step();
    got = {PCSrc, eq, lt, gt};
    n_checks++;
    if (got !== 4'b1001) begin
      n_fail++;
      $display("FAIL bgt_greater got=%b want=1001", got);
    end
    drive(16'h4545, 16'h4546, 3'b011);
    step();
    got = {PCSrc, eq, lt, gt};
    n_checks++;
    if (got !== 4'b0010) begin
      n_fail++;
      $display("FAIL bgt_less got=%b want=0010", got);
    end
  endtask

  task automatic test_none_jmp_reserved;
    logic [3:0] got;
    drive(16'hFF0F, 16'hFF0F, 3'b000);
    step();
    got = {PCSrc, eq, lt, gt};
    n_checks++;
    if (got !== 4'b0100) begin
      n_fail++;
      $display("FAIL none_equal got=%b want=0100", got);
    end
    drive(16'h1234, 16'h5678, 3'b100);
    step();
    got = {PCSrc, eq, lt, gt};
    n_checks++;
    if (got !== 4'b1010) begin
      n_fail++;
      $display("FAIL jmp got=%b want=1010", got);
    end
    drive(16'hFF0F, 16'hFF0F, 3'b111);
    step();
    got = {PCSrc, eq, lt, gt};
    n_checks++;
    if (got !== 4'b0100) begin
      n_fail++;
      $display("FAIL reserved_111 got=%b want=0100", got);
    end
    drive(16'h4545, 16'h4546, 3'b101);
    step();
    got = {PCSrc, eq, lt, gt};
    n_checks++;
    if (got !== 4'b0010) begin
      n_fail++;
      $display("FAIL reserved_101 got=%b want=0010", got);
    end
  endtask

  task automatic test_signedness;
    logic [3:0] got;
    logic [3:0] want;
`ifdef COMPARATOR_SIGNED_EN
    want = 4'b1001;
`else
    want = 4'b0010;
`endif
    drive(16'h7FFF, 16'h8000, 3'b011);
    step();
    got = {PCSrc, eq, lt, gt};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL signedness got=%b want=%b", got, want);
    end
  endtask

  // Each vector changes the inputs mid-cycle; outputs must hold until the next edge.
  task automatic test_back_to_back;
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [2:0]  vc [4];
    logic [3:0]  ve [4];
    logic [3:0]  prev;
    logic [3:0]  got;
    va[0] = 16'h0001; vb[0] = 16'h0001; vc[0] = 3'b001; ve[0] = 4'b1100;
    va[1] = 16'h0001; vb[1] = 16'h0002; vc[1] = 3'b010; ve[1] = 4'b1010;
    va[2] = 16'h0003; vb[2] = 16'h0002; vc[2] = 3'b000; ve[2] = 4'b0001;
    va[3] = 16'h0003; vb[3] = 16'h0002; vc[3] = 3'b100; ve[3] = 4'b1001;
    drive(16'h0005, 16'h0005, 3'b000);
    step();
    prev = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], vc[i]);
      #1;
      got = {PCSrc, eq, lt, gt};
      n_checks++;
      if (got !== prev) begin
        n_fail++;
        $display("FAIL b2b_hold_%0d got=%b want=%b", i, got, prev);
      end
      step();
      got = {PCSrc, eq, lt, gt};
      n_checks++;
      if (got !== ve[i]) begin
        n_fail++;
        $display("FAIL b2b_update_%0d got=%b want=%b", i, got, ve[i]);
      end
      prev = ve[i];
    end
  endtask

  task automatic test_reset_midstream;
    logic [3:0] got;
    drive(16'h0001, 16'h0001, 3'b100);
    rst = 1'b1;
    step();
    got = {PCSrc, eq, lt, gt};
    n_checks++;
    if (got !== 4'b0000) begin
      n_fail++;
      $display("FAIL midstream_reset got=%b want=0000", got);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    got = {PCSrc, eq, lt, gt};
    n_checks++;
    if (got !== 4'b1100) begin
      n_fail++;
      $display("FAIL midstream_release got=%b want=1100", got);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    r0       = 16'h0000;
    op1      = 16'h0000;
    CTRL     = 3'b000;
    test_reset();
    test_beq();
    test_blt();
    test_bgt();
    test_none_jmp_reserved();
    test_signedness();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
